tree_walk_sequencer: RTL
========================

Name: tree_walk_sequencer

Overview:
- Hardware iterator over a composition tree stored in an external node table.
- Each table entry holds two links: first_child and next_sibling.
- Starting from a root index, the block performs a pre-order depth-first walk and emits one visit record per node over a valid/ready stream.
- It sequences all node-table reads; downstream visitor logic only consumes the stream.

Parameters:
- IDX_W, 8, node index width. All-ones index (NULL) = no link.
- MAX_DEPTH, 16, maximum tree depth and pending-sibling stack entries. Depth field width DW = $clog2(MAX_DEPTH).
- MAX_VISITS, 2**IDX_W - 1, visit count limit per walk (cycle guard).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_valid  in  1  walk request
- start_ready  out  1  high only in IDLE
- start_root  in  IDX_W  root node index
- abort  in  1  cancel current walk
- busy  out  1  high when state != IDLE
- tbl_rd_en  out  1  node table read strobe
- tbl_rd_addr  out  IDX_W  node index to read
- tbl_rd_child  in  IDX_W  first_child, valid exactly 1 cycle after tbl_rd_en
- tbl_rd_sibling  in  IDX_W  next_sibling, same timing as tbl_rd_child
- visit_valid  out  1  visit record valid
- visit_ready  in  1  consumer accept
- visit_node  out  IDX_W  visited node index
- visit_depth  out  DW  root = 0
- visit_leaf  out  1  node has child == NULL
- visit_last  out  1  final visit of this walk
- done  out  1  1-cycle pulse at walk end
- err  out  1  qualifies done; walk terminated on a limit

Behaviour:
- Reset: state IDLE, stack empty, visit counter 0. start_ready=1; busy, tbl_rd_en, visit_valid, done, err = 0. tbl_rd_addr, visit_* fields = 0.
- State IDLE:
  - On start_valid&&start_ready, latch cur=(start_root, depth 0), set is_root=1, go to FETCH.
  - start_root == NULL: go straight to DONE with err=0 and no visits.
- State FETCH: tbl_rd_en=1 and tbl_rd_addr=cur.node for exactly one cycle, then go to RESP.
- State RESP: register child and sibling from the table; go to EMIT.
- State EMIT: visit_valid=1; node, depth and leaf are stable until handshake.
  - visit_last = (child==NULL) && stack empty && (sibling==NULL || is_root).
  - On visit_valid&&visit_ready, increment the visit count, then apply in order:
    1. If !is_root and sibling != NULL, push (sibling, depth).
    2. If child != NULL: if depth == MAX_DEPTH-1, go to DONE with err=1. Otherwise cur=(child, depth+1), clear is_root, go to FETCH.
    3. Else if the stack is non-empty: pop into cur, go to FETCH.
    4. Else go to DONE with err=0.
  - If the visit count reaches MAX_VISITS and the walk is not finished, go to DONE with err=1.
- State DONE: done=1 for one cycle, err as decided above, then go to IDLE.
- Root sibling is never followed.
- Stack occupancy is bounded by depth, so overflow is impossible; the depth check is the sole structural error.
- Latency:
  - Start handshake at cycle T gives tbl_rd_en at T+1 and first visit_valid at T+3.
  - Each later node: visit handshake at cycle V gives tbl_rd_en at V+1 and the next visit_valid at V+3.
  - done follows the last handshake by 1 cycle.
- Backpressure: visit_valid holds indefinitely with all fields stable; no table reads are issued while stalled.
- abort (priority over all but rst), sampled in any non-IDLE state:
  - Go to IDLE next cycle, clear the stack and counter.
  - No done pulse; visit_valid drops without handshake.
  - abort in IDLE is ignored.
- Same-cycle start and abort in IDLE: start is accepted and abort is ignored.
- rst mid-walk: identical to power-on reset on the next edge.

Test Plan:
- Single node: root=5, child=NULL, sibling=NULL → one visit (5, depth 0, leaf=1, last=1); done 1 cycle later, err=0.
- Tree 0→{1→{3}, 2}, i.e. child(0)=1, sib(1)=2, child(1)=3:
  - Visits in order: (0,d0), (1,d1), (3,d2,leaf), (2,d1,leaf,last); then done, err=0.
  - Check tbl_rd_en at T+1 and each V+1.
  - Root with a non-NULL sibling (sib(0)=7) is not followed; the sequence is unchanged.
- Backpressure: hold visit_ready=0 for 10 cycles at node 1 → visit fields stable, no tbl_rd_en pulses, resumes correctly.
- Depth limit, MAX_DEPTH=4: chain 0→1→2→3→4 → visits 0, 1, 2, 3, then done with err=1; node 4 is never read.
- Cycle guard: child(0)=1, child(1)=0, MAX_VISITS=6 → exactly 6 visits, then done with err=1.
- abort during EMIT of the 2nd visit → busy=0 and start_ready=1 next cycle, no done. A new start with root=5 then walks correctly.

Source files
------------

// File: rtl/tree_walk_sequencer_if.sv
// Start, table-read and visit-stream signals of the tree walk sequencer.
// The master side is the requester/table/consumer, the slave side is the walker.
interface tree_walk_sequencer_if #(
  parameter int IDX_W = 8,
  parameter int DW    = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [IDX_W-1:0] start_root;
  logic             abort;
  logic             busy;
  logic             tbl_rd_en;
  logic [IDX_W-1:0] tbl_rd_addr;
  logic [IDX_W-1:0] tbl_rd_child;
  logic [IDX_W-1:0] tbl_rd_sibling;
  logic             visit_valid;
  logic             visit_ready;
  logic [IDX_W-1:0] visit_node;
  logic [DW-1:0]    visit_depth;
  logic             visit_leaf;
  logic             visit_last;
  logic             done;
  logic             err;

  modport master (
    output start_valid, start_root, abort,
    output tbl_rd_child, tbl_rd_sibling, visit_ready,
    input  start_ready, busy, tbl_rd_en, tbl_rd_addr,
    input  visit_valid, visit_node, visit_depth,
    input  visit_leaf, visit_last, done, err
  );

  modport slave (
    input  start_valid, start_root, abort,
    input  tbl_rd_child, tbl_rd_sibling, visit_ready,
    output start_ready, busy, tbl_rd_en, tbl_rd_addr,
    output visit_valid, visit_node, visit_depth,
    output visit_leaf, visit_last, done, err
  );
endinterface

// File: rtl/tree_walk_sequencer.sv
// Pre-order depth-first walker over a first_child/next_sibling node table.
// Emits one visit record per node; pending siblings wait on a small stack.
module tree_walk_sequencer #(
  parameter int IDX_W      = 8,
  parameter int MAX_DEPTH  = 16,
  parameter int MAX_VISITS = 2**IDX_W - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  tree_walk_sequencer_if.slave bus
);
  localparam int DW  = $clog2(MAX_DEPTH);
  localparam int SPW = DW + 1;
  localparam int VW  = $clog2(MAX_VISITS + 1);
  localparam logic [IDX_W-1:0] NUL  = '1;
  localparam logic [DW-1:0]    DMAX = DW'(MAX_DEPTH - 1);
  localparam logic [VW-1:0]    VMAX = VW'(MAX_VISITS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RESP, S_EMIT, S_DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] node;
    logic [DW-1:0]    depth;
  } ent_t;

  state_t           state_q, state_d;
  ent_t             cur_q, cur_d;
  logic             is_root_q, is_root_d;
  logic [IDX_W-1:0] child_q, child_d;
  logic [IDX_W-1:0] sib_q, sib_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic             err_q, err_d;
  ent_t             stk_q [MAX_DEPTH];

  logic             push_en;
  ent_t             push_ent;
  logic             has_sib;
  logic [DW-1:0]    top_idx;

  assign has_sib = !is_root_q && (sib_q != NUL);
  assign top_idx = sp_q[DW-1:0] - DW'(1);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    is_root_d = is_root_q;
    child_d   = child_q;
    sib_d     = sib_q;
    sp_d      = sp_q;
    vcnt_d    = vcnt_q;
    err_d     = err_q;
    push_en   = 1'b0;
    push_ent  = '{node: sib_q, depth: cur_q.depth};
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          cur_d     = '{node: bus.start_root, depth: '0};
          is_root_d = 1'b1;
          sp_d      = '0;
          vcnt_d    = '0;
          err_d     = 1'b0;
          state_d   = (bus.start_root == NUL) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_RESP;
      S_RESP: begin
        child_d = bus.tbl_rd_child;
        sib_d   = bus.tbl_rd_sibling;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (bus.visit_ready) begin
          vcnt_d = vcnt_q + VW'(1);
          if (child_q != NUL) begin
            if (cur_q.depth == DMAX) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              push_en   = has_sib;
              cur_d     = '{node: child_q, depth: cur_q.depth + DW'(1)};
              is_root_d = 1'b0;
              state_d   = S_FETCH;
            end
          end else if (has_sib) begin
            // push immediately followed by pop: go straight to the sibling
            cur_d   = '{node: sib_q, depth: cur_q.depth};
            state_d = S_FETCH;
          end else if (sp_q != '0) begin
            cur_d   = stk_q[top_idx];
            sp_d    = sp_q - SPW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
          if (vcnt_d == VMAX && state_d == S_FETCH) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (push_en) sp_d = sp_q + SPW'(1);
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sp_d    = '0;
      vcnt_d  = '0;
      push_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      is_root_q <= 1'b0;
      child_q   <= '0;
      sib_q     <= '0;
      sp_q      <= '0;
      vcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      is_root_q <= is_root_d;
      child_q   <= child_d;
      sib_q     <= sib_d;
      sp_q      <= sp_d;
      vcnt_q    <= vcnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) stk_q[sp_q[DW-1:0]] <= push_ent;
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.tbl_rd_en   = (state_q == S_FETCH);
  assign bus.tbl_rd_addr = cur_q.node;
  assign bus.visit_valid = (state_q == S_EMIT);
  assign bus.visit_node  = cur_q.node;
  assign bus.visit_depth = cur_q.depth;
  assign bus.visit_leaf  = bus.visit_valid && (child_q == NUL);
  assign bus.visit_last  = bus.visit_leaf && (sp_q == '0) &&
                           ((sib_q == NUL) || is_root_q);
  assign bus.done        = (state_q == S_DONE);
  assign bus.err         = bus.done && err_q;
endmodule
